// File: rtl/io_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_master_if
// Brief    : CPU request/response handshake plus 8-bit-address IO bus bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface io_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, io_din,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output io_addr, io_dout, io_we, io_rd
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, io_din,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  io_addr, io_dout, io_we, io_rd
    );
endinterface
`default_nettype wire

// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_master
// Brief    : Single-request CPU initiator for the 256-byte MMIO window IO bus.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_master #(
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
    parameter int unsigned RD_LAT    = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    io_bus_master_if.master  bus
);
    localparam logic [3:0] C_RD_LAT = 4'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_io_addr;
    logic [31:0] r_io_dout;
    logic        r_io_we;
    logic        r_io_rd;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_ready;
    logic        w_err;

    assign w_ready = (r_state == S_IDLE) & ~rst;
    assign w_err   = (bus.req_addr[31:8] != MMIO_BASE[31:8]) | (bus.req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_io_addr   <= 8'd0;
            r_io_dout   <= 32'd0;
            r_io_we     <= 1'b0;
            r_io_rd     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_rsp_rdata <= 32'd0;
                        if (w_err) begin
                            // Rejected requests never touch the IO bus.
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_rsp_err <= 1'b0;
                            r_io_addr <= bus.req_addr[7:0];
                            if (bus.req_we) begin
                                r_io_dout <= bus.req_wdata;
                                r_io_we   <= 1'b1;
                                r_state   <= S_WR;
                            end else begin
                                r_io_rd <= 1'b1;
                                r_cnt   <= C_RD_LAT;
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_WR: begin
                    r_io_we     <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RD: begin
                    // io_din is sampled on the last cycle io_rd is held.
                    if (r_cnt == 4'd0) begin
                        r_rsp_rdata <= bus.io_din;
                        r_io_rd     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_io_we     <= 1'b0;
                    r_io_rd     <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.io_addr   = r_io_addr;
    assign bus.io_dout   = r_io_dout;
    assign bus.io_we     = r_io_we;
    assign bus.io_rd     = r_io_rd;
endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_master
// Brief    : Bench for io_bus_master with RD_LAT=0 and RD_LAT=3 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_master;
    localparam logic [31:0] C_BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] din = 32'd0;
    int          din_mode = 0;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    io_bus_master_if bus0 ();
    io_bus_master_if bus1 ();

    io_bus_master #(.MMIO_BASE(C_BASE), .RD_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
    io_bus_master #(.MMIO_BASE(C_BASE), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus1.master));

    assign bus0.req_valid = req_valid & ~sel;
    assign bus1.req_valid = req_valid & sel;
    assign bus0.req_we    = req_we;
    assign bus1.req_we    = req_we;
    assign bus0.req_addr  = req_addr;
    assign bus1.req_addr  = req_addr;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_wdata = req_wdata;
    assign bus0.io_din    = din;
    assign bus1.io_din    = din;

    logic        ready_m, we_m, rd_m, rv_m, err_m;
    logic [7:0]  addr_m;
    logic [31:0] dout_m, rdata_m;
    assign ready_m = sel ? bus1.req_ready : bus0.req_ready;
    assign we_m    = sel ? bus1.io_we     : bus0.io_we;
    assign rd_m    = sel ? bus1.io_rd     : bus0.io_rd;
    assign rv_m    = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign err_m   = sel ? bus1.rsp_err   : bus0.rsp_err;
    assign addr_m  = sel ? bus1.io_addr   : bus0.io_addr;
    assign dout_m  = sel ? bus1.io_dout   : bus0.io_dout;
    assign rdata_m = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: each accepted request is turned into the
    // cycle windows in which strobes and the response must appear.
    int          cyc = 0;
    int          free_at = 0;
    int          we_cyc = -1, rd_lo = 0, rd_hi = -1, rsp_cyc = -1;
    bit          pending = 0, inited = 0, e_load = 0, e_err = 0;
    bit          e_ready, e_we, e_rd, e_rv;
    logic [7:0]  m_addr [2];
    logic [31:0] m_dout [2];
    logic [31:0] m_rdata = 32'd0;
    int          lat;

    always @(negedge clk) begin
        e_ready = !rst && (cyc >= free_at);
        if (inited) begin
            e_we = pending && (cyc == we_cyc);
            e_rd = pending && (cyc >= rd_lo) && (cyc <= rd_hi);
            e_rv = pending && (cyc == rsp_cyc);
            chk("req_ready", 32'(ready_m), 32'(e_ready));
            chk("io_we", 32'(we_m), 32'(e_we));
            chk("io_rd", 32'(rd_m), 32'(e_rd));
            chk("rsp_valid", 32'(rv_m), 32'(e_rv));
            chk("io_addr", 32'(addr_m), 32'(m_addr[sel]));
            chk("io_dout", dout_m, m_dout[sel]);
            chk("strobe_overlap", 32'(we_m & rd_m), 32'd0);
            if (e_rv) begin
                chk("rsp_err", 32'(err_m), 32'(e_err));
                chk("rsp_rdata", rdata_m, e_load ? m_rdata : 32'd0);
                pending = 0;
            end
            if (pending && cyc == rd_hi) m_rdata = din;
        end else if (rst) begin
            chk("req_ready_in_reset", 32'(ready_m), 32'd0);
        end

        if (rst) begin
            inited  = 1;
            pending = 0;
            free_at = cyc + 1;
            for (int k = 0; k < 2; k++) begin
                m_addr[k] = 8'd0;
                m_dout[k] = 32'd0;
            end
        end else if (inited && e_ready && req_valid) begin
            pending = 1;
            we_cyc  = -1;
            rd_lo   = 0;
            rd_hi   = -1;
            e_load  = 0;
            e_err   = (req_addr[31:8] != C_BASE[31:8]) || (req_addr[1:0] != 2'b00);
            lat     = sel ? 3 : 0;
            if (e_err) begin
                rsp_cyc = cyc + 1;
                free_at = cyc + 2;
            end else if (req_we) begin
                m_addr[sel] = req_addr[7:0];
                m_dout[sel] = req_wdata;
                we_cyc  = cyc + 1;
                rsp_cyc = cyc + 2;
                free_at = cyc + 3;
            end else begin
                m_addr[sel] = req_addr[7:0];
                e_load  = 1;
                rd_lo   = cyc + 1;
                rd_hi   = cyc + 1 + lat;
                rsp_cyc = cyc + 2 + lat;
                free_at = cyc + 3 + lat;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (din_mode == 1) din = $urandom;
        else if (din_mode == 2) din = din + 32'd1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Returns in the cycle after the accepting edge.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit acc;
        acc       = 0;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc = ready_m;
            tick();
            if (acc) break;
        end
        req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_err_rsp(input string nm);
        @(negedge clk);
        chk({nm, "_rv"}, 32'(rv_m), 32'd1);
        chk({nm, "_err"}, 32'(err_m), 32'd1);
        chk({nm, "_rdata"}, rdata_m, 32'd0);
        chk({nm, "_nostrobe"}, 32'({we_m, rd_m}), 32'd0);
        chk({nm, "_addr"}, 32'(addr_m), 32'h14);
        chk({nm, "_dout"}, dout_m, 32'h0000_A5A5);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        chk("reset_io_addr", 32'(addr_m), 32'd0);
        chk("reset_rsp_valid", 32'(rv_m), 32'd0);
        chk("reset_ready", 32'(ready_m), 32'd0);
        tick();
        rst = 1'b0;
        idle(2);

        // Store with literal expectations.
        send(1'b1, 32'hFFFF_FF00, 32'h0000_A5A5);
        @(negedge clk);
        chk("st_we", 32'(we_m), 32'd1);
        chk("st_addr", 32'(addr_m), 32'h00);
        chk("st_dout", dout_m, 32'h0000_A5A5);
        tick();
        @(negedge clk);
        chk("st_rv", 32'(rv_m), 32'd1);
        chk("st_err", 32'(err_m), 32'd0);
        chk("st_rdata", rdata_m, 32'd0);
        idle(3);

        // Load, RD_LAT=0.
        din = 32'hDEAD_BEEF;
        send(1'b0, 32'hFFFF_FF14, 32'd0);
        @(negedge clk);
        chk("ld0_rd", 32'(rd_m), 32'd1);
        tick();
        @(negedge clk);
        chk("ld0_rd_off", 32'(rd_m), 32'd0);
        chk("ld0_rv", 32'(rv_m), 32'd1);
        chk("ld0_rdata", rdata_m, 32'hDEAD_BEEF);
        idle(3);

        // Out-of-window and misaligned requests.
        send(1'b0, 32'h0000_1000, 32'd0);
        check_err_rsp("err_win");
        idle(1);
        send(1'b1, 32'hFFFF_FF0D, 32'h1234_5678);
        check_err_rsp("err_mis");
        idle(2);

        // Back-to-back store then load with req_valid held high.
        req_we = 1'b1; req_addr = 32'hFFFF_FF08; req_wdata = 32'h1122_3344; req_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ready0", 32'(ready_m), 32'd1);
        tick();
        req_we = 1'b0; req_addr = 32'hFFFF_FF0C;
        @(negedge clk);
        chk("b2b_ready1", 32'(ready_m), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b_ready2", 32'(ready_m), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b_ready3", 32'(ready_m), 32'd1);
        tick();
        req_valid = 1'b0;
        idle(4);

        // Load, RD_LAT=3, with io_din stepping 1,2,3,4.
        sel = 1'b1;
        idle(2);
        din_mode = 2;
        din = 32'd0;
        send(1'b0, 32'hFFFF_FF20, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ld3_rd", 32'(rd_m), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("ld3_rv", 32'(rv_m), 32'd1);
        chk("ld3_rdata", rdata_m, 32'd4);
        tick();
        din_mode = 0;
        idle(3);

        // Reset in the first RD cycle aborts the load.
        send(1'b0, 32'hFFFF_FF24, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rd", 32'(rd_m), 32'd0);
        chk("abort_addr", 32'(addr_m), 32'd0);
        chk("abort_dout", dout_m, 32'd0);
        chk("abort_rdata", rdata_m, 32'd0);
        chk("abort_err", 32'(err_m), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rv_m), 32'd0);
            tick();
        end

        // Randomized traffic on both latencies.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            idle(8);
            din_mode = 1;
            for (int t = 0; t < 80; t++) begin
                int cls;
                logic [31:0] a;
                cls = $urandom_range(0, 5);
                a = {C_BASE[31:8], 6'($urandom_range(0, 63)), 2'b00};
                if (cls == 4) a[1:0] = 2'($urandom_range(1, 3));
                if (cls == 5) a = $urandom;
                send(1'($urandom_range(0, 1)), a, $urandom);
                idle($urandom_range(0, 3));
            end
            din_mode = 0;
            idle(10);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
